// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: 2-entry skid-buffer pipeline register with registered in_ready.
// Define PIPE_STAGE_STATS_EN to enable the saturating downstream stall counter.
module pipe_stage_reg #(
  parameter int PD_W = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PD_W-1:0] in_pd,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_rf_le,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PD_W-1:0] out_pd,
  output logic [RD_W-1:0] out_rd,
  output logic            out_rf_le,
  output logic [15:0]     stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  logic in_ready_q, in_ready_d;
  logic [PD_W-1:0] main_pd_q, main_pd_d, skid_pd_q, skid_pd_d;
  logic [RD_W-1:0] main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
  logic main_le_q, main_le_d, skid_le_q, skid_le_d;
  logic accept, drain, main_load, skid_load, main_from_skid;
  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid & out_ready;
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_pd_q  <= '0;
      main_rd_q  <= '0;
      main_le_q  <= 1'b0;
      skid_pd_q  <= '0;
      skid_rd_q  <= '0;
      skid_le_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_pd_q  <= main_pd_d;
      main_rd_q  <= main_rd_d;
      main_le_q  <= main_le_d;
      skid_pd_q  <= skid_pd_d;
      skid_rd_q  <= skid_rd_d;
      skid_le_q  <= skid_le_d;
    end
  end
  always_comb begin
    state_d = flush            ? EMPTY :
              state_q == EMPTY ? (accept ? ONE : EMPTY) :
              state_q == ONE   ? ((accept & ~drain) ? FULL : (~accept & drain) ? EMPTY : ONE) :
                                 (drain ? ONE : FULL);
    in_ready_d = state_d != FULL;
  end
  // Flush only moves the state; data registers keep their contents so outputs hold.
  always_comb begin
    main_load      = ~flush & accept & (state_q == EMPTY | (state_q == ONE & drain));
    skid_load      = ~flush & accept & state_q == ONE & ~drain;
    main_from_skid = ~flush & state_q == FULL & drain;
    main_pd_d = main_load ? in_pd    : main_from_skid ? skid_pd_q : main_pd_q;
    main_rd_d = main_load ? in_rd    : main_from_skid ? skid_rd_q : main_rd_q;
    main_le_d = main_load ? in_rf_le : main_from_skid ? skid_le_q : main_le_q;
    skid_pd_d = skid_load ? in_pd    : skid_pd_q;
    skid_rd_d = skid_load ? in_rd    : skid_rd_q;
    skid_le_d = skid_load ? in_rf_le : skid_le_q;
  end
  always_comb begin
    out_valid = state_q != EMPTY;
    out_rf_le = out_valid & main_le_q;
    out_pd    = main_pd_q;
    out_rd    = main_rd_q;
    in_ready  = in_ready_q;
  end
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_q, stall_d;
  always_comb stall_d = (out_valid & ~out_ready & ~&stall_q) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif
endmodule
